// File: rtl/spi_pkg.sv
// Shared encodings, frame lengths and FSM states for the SPI main.
package spi_pkg;

    localparam logic [1:0] KS_128 = 2'b00;
    localparam logic [1:0] KS_192 = 2'b01;
    localparam logic [1:0] KS_256 = 2'b10;
    localparam logic [1:0] KS_ILL = 2'b11;

    localparam logic [8:0] FRAME_LEN_128 = 9'd130;
    localparam logic [8:0] FRAME_LEN_192 = 9'd194;
    localparam logic [8:0] FRAME_LEN_256 = 9'd258;

    localparam int RX_BITS = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SCK_HI,
        ST_SCK_LO,
        ST_TAIL_HI,
        ST_TAIL_LO,
        ST_GUARD
    } state_e;

    function automatic logic [8:0] frame_len(input logic [1:0] ks);
        logic [8:0] len;
        case (ks)
            KS_192:  len = FRAME_LEN_192;
            KS_256:  len = FRAME_LEN_256;
            default: len = FRAME_LEN_128;
        endcase
        return len;
    endfunction

    // Bit idx of the frame: two header bits, then payload from bit 255 down.
    function automatic logic frame_bit(
        input logic [1:0]   ks,
        input logic [255:0] pl,
        input logic [8:0]   idx
    );
        logic [7:0] pos;
        pos = 8'(9'd257 - idx);
        if (idx == 9'd0) begin
            return ks[1];
        end
        if (idx == 9'd1) begin
            return ks[0];
        end
        return pl[pos];
    endfunction

endpackage

// File: rtl/spi_main_tick.sv
// Phase timer: ticks on the last clk cycle of every CLK_DIV-long phase.
module spi_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick_o = !clear_i && (cnt_q == LAST);

    // Every state change lands on a tick, so wrapping here restarts the phase.
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_main.sv
// SPI main: sends a key_size header plus payload frame MSB first
// and captures the first 128 bits returned by the subordinate.
module spi_main
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_size,
    input  logic [255:0] payload,
    output logic         cs,
    output logic         sclk,
    output logic         sdi,
    input  logic         sdo,
    output logic [127:0] rx_data,
    output logic         busy,
    output logic         done,
    output logic         err
);

    state_e         state_q;
    state_e         state_d;
    logic [8:0]     bit_q;
    logic [8:0]     bit_d;
    logic           last_q;
    logic           last_d;
    logic           sdi_q;
    logic           sdi_d;
    logic [127:0]   rx_q;
    logic [127:0]   rx_d;
    logic [1:0]     ks_q;
    logic [1:0]     ks_d;
    logic [255:0]   pl_q;
    logic [255:0]   pl_d;
    logic           done_q;
    logic           done_d;
    logic           err_q;
    logic           err_d;
    logic           tick;
    logic           idle;
    logic [8:0]     last_idx;

    assign idle     = (state_q == ST_IDLE);
    assign last_idx = frame_len(ks_q) - 9'd1;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (idle),
        .tick_o  (tick)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        last_d  = last_q;
        sdi_d   = sdi_q;
        rx_d    = rx_q;
        ks_d    = ks_q;
        pl_d    = pl_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (key_size == KS_ILL) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_LEAD;
                        ks_d    = key_size;
                        pl_d    = payload;
                        bit_d   = '0;
                        last_d  = 1'b0;
                        sdi_d   = key_size[1];
                    end
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    state_d = ST_SCK_HI;
                end
            end
            ST_SCK_HI: begin
                // Falling sclk edge: capture sdo, then move sdi on.
                if (tick) begin
                    state_d = ST_SCK_LO;
                    if (bit_q < 9'(RX_BITS)) begin
                        rx_d = {rx_q[126:0], sdo};
                    end
                    if (bit_q == last_idx) begin
                        last_d = 1'b1;
                        sdi_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 9'd1;
                        sdi_d = frame_bit(ks_q, pl_q, bit_q + 9'd1);
                    end
                end
            end
            ST_SCK_LO: begin
                if (tick) begin
                    state_d = last_q ? ST_TAIL_HI : ST_SCK_HI;
                end
            end
            ST_TAIL_HI: begin
                if (tick) begin
                    state_d = ST_TAIL_LO;
                end
            end
            ST_TAIL_LO: begin
                if (tick) begin
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            last_q  <= 1'b0;
            sdi_q   <= 1'b0;
            rx_q    <= '0;
            ks_q    <= '0;
            pl_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            sdi_q   <= sdi_d;
            rx_q    <= rx_d;
            ks_q    <= ks_d;
            pl_q    <= pl_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cs      = idle || (state_q == ST_GUARD);
    assign sclk    = (state_q == ST_SCK_HI) || (state_q == ST_TAIL_HI);
    assign sdi     = sdi_q;
    assign rx_data = rx_q;
    assign busy    = !idle;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_spi_main.sv
// Testbench for spi_main: timing model of the frame plus a subordinate
// that shifts a 128-bit word out on sdo.
module tb_spi_main;

    localparam int DIV = 2;
    localparam int LIMIT = 4000;

    localparam logic [255:0] PL_A =
        {128'h0123456789ABCDEF0123456789ABCDEF,
         128'hDEADBEEFCAFEF00D1357924680ACE135};
    localparam logic [255:0] PL_B =
        {128'hF0E1D2C3B4A5968778695A4B3C2D1E0F,
         128'h55AA33CC0FF00FF0123456789ABCDEF0};
    localparam logic [127:0] WORD_A = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
    localparam logic [127:0] WORD_B = 128'h3C0F96E1_00FF7E81_DB24C3A5_5A18E7F0;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   key_size;
    logic [255:0] payload;
    logic         cs;
    logic         sclk;
    logic         sdi;
    logic         sdo;
    logic [127:0] rx_data;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int failures = 0;

    logic [127:0] sub_word;
    int           sub_idx;
    int           rises;
    logic [15:0]  first16;
    logic [63:0]  hist64;

    logic         fb [0:257];

    spi_main #(
        .CLK_DIV (DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_size (key_size),
        .payload  (payload),
        .cs       (cs),
        .sclk     (sclk),
        .sdi      (sdi),
        .sdo      (sdo),
        .rx_data  (rx_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Subordinate: shifts sdo out on rising sclk, notes sdi while sclk is high.
    initial begin
        sub_idx = 127;
        rises = 0;
        first16 = '0;
        hist64 = '0;
        forever begin
            @(posedge sclk or negedge cs);
            if (sclk) begin
                if (rises < 16) first16 = {first16[14:0], sdi};
                hist64 = {hist64[62:0], sdi};
                rises++;
                sdo = (sub_idx >= 0) ? sub_word[sub_idx] : 1'b0;
                sub_idx--;
            end else begin
                sub_idx = 127;
                rises = 0;
                first16 = '0;
            end
        end
    end

    // Frame model: offset t from the accepting edge, phase p = t / DIV.
    initial begin : cmp
        logic         e_start;
        logic         e_rst;
        logic [1:0]   e_ks;
        logic [255:0] e_pl;
        logic         m_act;
        int           m_t;
        int           m_n;
        int           m_end;
        logic [127:0] m_word;
        logic [127:0] m_hold;
        logic         x_done;
        logic         x_err;
        logic         x_cs;
        logic         x_sclk;
        logic         x_sdi;
        int           p;
        m_act = 1'b0;
        m_t = 0;
        m_n = 130;
        m_end = 0;
        m_word = '0;
        m_hold = '0;
        forever begin
            @(posedge clk);
            e_start = start;
            e_rst = rst;
            e_ks = key_size;
            e_pl = payload;
            @(negedge clk);
            #1;
            x_done = 1'b0;
            x_err = 1'b0;
            if (rst || e_rst) begin
                m_act = 1'b0;
                m_hold = '0;
                chk("rst_cs", 128'(cs), 128'd1);
                chk("rst_sclk", 128'(sclk), 128'd0);
                chk("rst_sdi", 128'(sdi), 128'd0);
                chk("rst_busy", 128'(busy), 128'd0);
                chk("rst_done", 128'(done), 128'd0);
                chk("rst_err", 128'(err), 128'd0);
                chk("rst_rx", rx_data, 128'd0);
            end else begin
                if (m_act) begin
                    m_t++;
                    if (m_t == m_end) begin
                        m_act = 1'b0;
                        x_done = 1'b1;
                        m_hold = m_word;
                    end
                end else if (e_start) begin
                    if (e_ks == 2'b11) begin
                        x_err = 1'b1;
                    end else begin
                        m_act = 1'b1;
                        m_t = 0;
                        m_n = 130 + 64 * int'(e_ks);
                        m_end = (2 * m_n + 4) * DIV;
                        m_word = sub_word;
                        fb[0] = e_ks[1];
                        fb[1] = e_ks[0];
                        for (int i = 0; i < 256; i++) fb[2 + i] = e_pl[255 - i];
                    end
                end
                if (m_act) begin
                    p = m_t / DIV;
                    x_cs = (p == 2 * m_n + 3);
                    x_sclk = (p % 2 == 1) && (p <= 2 * m_n + 1);
                    x_sdi = (p / 2 < m_n) ? fb[p / 2] : 1'b0;
                end else begin
                    x_cs = 1'b1;
                    x_sclk = 1'b0;
                    x_sdi = 1'b0;
                    chk("rx_hold", rx_data, m_hold);
                end
                chk("cs", 128'(cs), 128'(x_cs));
                chk("sclk", 128'(sclk), 128'(x_sclk));
                chk("sdi", 128'(sdi), 128'(x_sdi));
                chk("busy", 128'(busy), 128'(m_act));
                chk("done", 128'(done), 128'(x_done));
                chk("err", 128'(err), 128'(x_err));
                if (x_done) begin
                    chk("rx_at_done", rx_data, m_word);
                    chk("rises_at_done", 128'(rises), 128'(m_n + 1));
                end
            end
        end
    end

    task automatic run_frame(input logic [1:0] ks, input logic [255:0] pl,
                             input logic [127:0] word, input int inj,
                             output int dt);
        sub_word = word;
        key_size = ks;
        payload = pl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dt = 0;
        while (done !== 1'b1 && dt < LIMIT) begin
            @(negedge clk);
            dt++;
            if (dt == inj) begin
                start = 1'b1;
                key_size = 2'b10;
                payload = ~pl;
            end else if (dt == inj + 1) begin
                start = 1'b0;
            end
        end
    endtask

    initial begin : stim
        int dt;
        int cnt;
        int hi_run;
        rst = 1'b1;
        start = 1'b0;
        key_size = 2'b00;
        payload = '0;
        sdo = 1'b0;
        sub_word = '0;
        repeat (3) @(negedge clk);
        chk("reset_cs", 128'(cs), 128'd1);
        chk("reset_rx", rx_data, 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(2'b00, PL_A, WORD_A, -1, dt);
        chk("lat_128", 128'(dt), 128'd528);
        chk("rises_128", 128'(rises), 128'd131);
        chk("rx_128", rx_data, 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5);
        chk("sdi_head", 128'(first16), 128'h0048);
        chk("sdi_tail", 128'(hist64), 128'h02468ACF13579BDE);
        repeat (4) @(negedge clk);

        run_frame(2'b01, PL_B, WORD_B, -1, dt);
        chk("lat_192", 128'(dt), 128'd784);
        chk("rises_192", 128'(rises), 128'd195);
        chk("rx_192", rx_data, WORD_B);
        repeat (4) @(negedge clk);

        run_frame(2'b10, PL_B, WORD_A, -1, dt);
        chk("lat_256", 128'(dt), 128'd1040);
        chk("rises_256", 128'(rises), 128'd259);
        repeat (4) @(negedge clk);

        key_size = 2'b11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key_size = 2'b00;
        cnt = int'(err);
        chk("err_busy", 128'(busy), 128'd0);
        chk("err_cs", 128'(cs), 128'd1);
        repeat (4) begin
            @(negedge clk);
            cnt += int'(err);
        end
        chk("err_pulses", 128'(cnt), 128'd1);
        chk("err_rx_kept", rx_data, WORD_A);

        run_frame(2'b00, PL_A, WORD_B, 162, dt);
        chk("lat_ignored", 128'(dt), 128'd528);
        chk("rises_ignored", 128'(rises), 128'd131);
        chk("rx_ignored", rx_data, WORD_B);
        repeat (4) @(negedge clk);

        sub_word = WORD_A;
        key_size = 2'b00;
        payload = PL_A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (202) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_cs", 128'(cs), 128'd1);
        chk("abort_sclk", 128'(sclk), 128'd0);
        chk("abort_rx", rx_data, 128'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_frame(2'b00, PL_B, WORD_A, -1, dt);
        chk("lat_after_rst", 128'(dt), 128'd528);
        chk("rx_after_rst", rx_data, WORD_A);
        repeat (4) @(negedge clk);

        sub_word = WORD_B;
        key_size = 2'b00;
        payload = PL_A;
        start = 1'b1;
        @(negedge clk);
        dt = 0;
        hi_run = 0;
        while (done !== 1'b1 && dt < LIMIT) begin
            @(negedge clk);
            dt++;
            hi_run = cs ? hi_run + 1 : 0;
        end
        chk("b2b_lat1", 128'(dt), 128'd528);
        chk("b2b_gap", 128'(hi_run), 128'd3);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_cs_low", 128'(cs), 128'd0);
        chk("b2b_busy", 128'(busy), 128'd1);
        dt = 0;
        while (done !== 1'b1 && dt < LIMIT) begin
            @(negedge clk);
            dt++;
        end
        chk("b2b_lat2", 128'(dt), 128'd528);
        chk("b2b_rx", rx_data, WORD_B);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
